xor_share_ctrl: RTL

Round-robin controller that shares the single XOR datapath (`dut` behind `dut_if`) among NUM_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake, drives the datapath operands, and captures the registered result. It returns the result with the winning requester's id over a held response channel. It sits between the requester ports and the datapath, and owns the datapath's active-high reset.

---
 rtl/xor_share_pkg.sv | 14 +
 rtl/xor_rr_pick.sv | 31 +++
 rtl/xor_share_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/xor_share_pkg.sv
// rtl/xor_share_pkg.sv - shared types and constants for the XOR datapath share controller
package xor_share_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int XS_DATA_W = 32;
  localparam int PERF_W    = 16;

endpackage

// File: rtl/xor_rr_pick.sv
// rtl/xor_rr_pick.sv - combinational round-robin search starting after last_grant
module xor_rr_pick
  import xor_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               found
);

  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/xor_share_ctrl.sv
// rtl/xor_share_ctrl.sv - round-robin share of one XOR datapath among NUM_REQ requesters
// Optional per-requester grant counters under XOR_SHARE_CTRL_PERF_EN.
module xor_share_ctrl
  import xor_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = XS_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_in1,
  input  logic [NUM_REQ*DATA_W-1:0] req_in2,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      dp_reset,
  output logic [DATA_W-1:0]         dp_in1,
  output logic [DATA_W-1:0]         dp_in2,
  input  logic [DATA_W-1:0]         dp_result
`ifdef XOR_SHARE_CTRL_PERF_EN
  ,
  output logic [NUM_REQ*PERF_W-1:0] perf_grant_cnt
`endif
);

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    pend_id;
  logic [ID_W-1:0]    pick_id;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_found;
  logic               can_accept;
  logic               accept;

  xor_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_onehot),
    .grant_id   (pick_id),
    .found      (pick_found)
  );

  // Grants are held off until the datapath is out of reset.
  assign can_accept = (state == IDLE) && !dp_reset;
  assign req_ready  = can_accept ? pick_onehot : '0;
  assign accept     = can_accept && pick_found;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dp_reset   <= 1'b1;
      last_grant <= ID_W'(NUM_REQ - 1);
      pend_id    <= '0;
      dp_in1     <= '0;
      dp_in2     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      dp_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dp_in1     <= req_in1[int'(pick_id)*DATA_W +: DATA_W];
            dp_in2     <= req_in2[int'(pick_id)*DATA_W +: DATA_W];
            pend_id    <= pick_id;
            last_grant <= pick_id;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          rsp_data  <= dp_result;
          rsp_id    <= pend_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XOR_SHARE_CTRL_PERF_EN
  logic [NUM_REQ-1:0][PERF_W-1:0] perf_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_cnt <= '0;
    end else if (accept && (perf_cnt[pick_id] != '1)) begin
      perf_cnt[pick_id] <= perf_cnt[pick_id] + 1'b1;
    end
  end

  assign perf_grant_cnt = perf_cnt;
`endif

endmodule
